// File: rtl/vic_sound_pkg.sv
// Shared constants for the VIC-I sound block: register offsets, divider defaults and the noise LFSR step.
package vic_sound_pkg;

    localparam logic [3:0] REG_BASS    = 4'hA;
    localparam logic [3:0] REG_ALTO    = 4'hB;
    localparam logic [3:0] REG_SOPRANO = 4'hC;
    localparam logic [3:0] REG_NOISE   = 4'hD;
    localparam logic [3:0] REG_VOL     = 4'hE;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int BASS_DIV_DEF    = 16;
    localparam int ALTO_DIV_DEF    = 8;
    localparam int SOPRANO_DIV_DEF = 4;
    localparam int NOISE_DIV_DEF   = 32;

    // Fibonacci form of x^16+x^14+x^13+x^11, shifting towards the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vic_sound_voice.sv
// One voice: clken prescaler, 7-bit up-counter reloaded from F at 7F, and a toggle flop.
// With NOISE set, out_o is instead a one-clk pulse on every counter wrap.
module vic_sound_voice #(
    parameter int DIV   = 16,
    parameter bit NOISE = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clken_i,
    input  logic       en_i,
    input  logic [6:0] f_i,
    output logic       out_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          tog_q, tog_d;
    logic          wrap;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        wrap    = 1'b0;
        if (!en_i) begin
            presc_d = '0;
            cnt_d   = f_i;
            tog_d   = 1'b0;
        end else if (clken_i) begin
            if (presc_q == PW'(DIV - 1)) begin
                presc_d = '0;
                // f_i here is the pre-write value when a write lands on this clk
                if (cnt_q == 7'h7F) begin
                    cnt_d = f_i;
                    wrap  = 1'b1;
                    if (!NOISE) tog_d = ~tog_q;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
            tog_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
        end
    end

    assign out_o = NOISE ? wrap : (en_i & tog_q);

endmodule

// File: rtl/vic_sound.sv
// VIC-I (6560) sound: $900A-$900E registers with readback, 3 square voices, LFSR noise, volume mixer.
// Audio is registered on clken; VIC_SOUND_FILTER_EN adds a one-pole smoothing accumulator.
module vic_sound
    import vic_sound_pkg::*;
#(
    parameter int          BASS_DIV    = BASS_DIV_DEF,
    parameter int          ALTO_DIV    = ALTO_DIV_DEF,
    parameter int          SOPRANO_DIV = SOPRANO_DIV_DEF,
    parameter int          NOISE_DIV   = NOISE_DIV_DEF,
    parameter logic [15:0] LFSR_SEED   = 16'h0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       cs,
    input  logic [3:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [3:0] audio
);

    logic [7:0]  bass_q, bass_d, alto_q, alto_d, sop_q, sop_d, noise_q, noise_d, vol_q, vol_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        bass_out, alto_out, sop_out, noise_step, noise_out;
    logic [2:0]  sum;
    logic [5:0]  mix;

    always_comb begin
        bass_d  = bass_q;
        alto_d  = alto_q;
        sop_d   = sop_q;
        noise_d = noise_q;
        vol_d   = vol_q;
        if (cs && we) begin
            case (addr)
                REG_BASS:    bass_d  = wdata;
                REG_ALTO:    alto_d  = wdata;
                REG_SOPRANO: sop_d   = wdata;
                REG_NOISE:   noise_d = wdata;
                REG_VOL:     vol_d   = wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cs) begin
            case (addr)
                REG_BASS:    rdata_d = bass_q;
                REG_ALTO:    rdata_d = alto_q;
                REG_SOPRANO: rdata_d = sop_q;
                REG_NOISE:   rdata_d = noise_q;
                REG_VOL:     rdata_d = vol_q;
                default:     rdata_d = 8'h00;
            endcase
        end
    end

    vic_sound_voice #(.DIV(BASS_DIV), .NOISE(1'b0)) u_bass (
        .clk_i(clk), .reset_i(reset), .clken_i(clken),
        .en_i(bass_q[7]), .f_i(bass_q[6:0]), .out_o(bass_out));

    vic_sound_voice #(.DIV(ALTO_DIV), .NOISE(1'b0)) u_alto (
        .clk_i(clk), .reset_i(reset), .clken_i(clken),
        .en_i(alto_q[7]), .f_i(alto_q[6:0]), .out_o(alto_out));

    vic_sound_voice #(.DIV(SOPRANO_DIV), .NOISE(1'b0)) u_soprano (
        .clk_i(clk), .reset_i(reset), .clken_i(clken),
        .en_i(sop_q[7]), .f_i(sop_q[6:0]), .out_o(sop_out));

    vic_sound_voice #(.DIV(NOISE_DIV), .NOISE(1'b1)) u_noise (
        .clk_i(clk), .reset_i(reset), .clken_i(clken),
        .en_i(noise_q[7]), .f_i(noise_q[6:0]), .out_o(noise_step));

    // The enable bit never reseeds the LFSR; it only gates the noise output
    assign lfsr_d    = noise_step ? lfsr_next(lfsr_q) : lfsr_q;
    assign noise_out = noise_q[7] & lfsr_q[0];

    assign sum = {2'b00, bass_out} + {2'b00, alto_out} + {2'b00, sop_out} + {2'b00, noise_out};
    assign mix = {3'b000, sum} * {2'b00, vol_q[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bass_q  <= 8'h00;
            alto_q  <= 8'h00;
            sop_q   <= 8'h00;
            noise_q <= 8'h00;
            vol_q   <= 8'h00;
            rdata_q <= 8'h00;
            lfsr_q  <= LFSR_SEED;
        end else begin
            bass_q  <= bass_d;
            alto_q  <= alto_d;
            sop_q   <= sop_d;
            noise_q <= noise_d;
            vol_q   <= vol_d;
            rdata_q <= rdata_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign rdata = rdata_q;

`ifdef VIC_SOUND_FILTER_EN
    logic [7:0]        acc_q, acc_d;
    logic signed [8:0] diff;

    always_comb begin
        diff  = $signed({1'b0, mix, 2'b00}) - $signed({1'b0, acc_q});
        acc_d = acc_q;
        if (clken) acc_d = acc_q + 8'(diff >>> 2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= 8'h00;
        else       acc_q <= acc_d;
    end

    assign audio = acc_q[7:4];
`else
    logic [3:0] audio_q, audio_d;

    assign audio_d = clken ? mix[5:2] : audio_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) audio_q <= 4'h0;
        else       audio_q <= audio_d;
    end

    assign audio = audio_q;
`endif

endmodule

// File: tb/tb_vic_sound.sv
// Scoreboard bench for vic_sound: expected audio transitions (value + tick spacing) and read data are queued by the stimulus and checked by monitors.
module tb_vic_sound;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clken, cs, we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [3:0] audio;

    vic_sound dut (
        .clk(clk), .reset(reset), .clken(clken), .cs(cs), .addr(addr),
        .we(we), .wdata(wdata), .rdata(rdata), .audio(audio));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        int         ivl;
    } aud_exp_t;

    aud_exp_t   aud_q[$];
    logic [7:0] rd_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    int         tick_cnt = 0;
    int         last_tick = 0;
    logic [3:0] last_aud = 4'h0;
    bit         rd_seen = 1'b0;
    int         cdiv = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at tick %0d", name, got, exp, tick_cnt);
        end
    endtask

    // clken: one clk high in every four
    initial begin
        clken = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cdiv  = (cdiv == 3) ? 0 : cdiv + 1;
            clken = (cdiv == 3);
        end
    end

    always @(posedge clk) begin
        if (clken) tick_cnt <= tick_cnt + 1;
        rd_seen <= cs && !we;
    end

    task automatic mon_step();
        aud_exp_t e;
        logic [7:0] er;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rdata_unexpected got=%02h expected=none", rdata);
            end else begin
                er = rd_q.pop_front();
                check("rdata", {24'h0, rdata}, {24'h0, er});
            end
        end
        if (audio !== last_aud) begin
            if (mon_en) begin
                if (aud_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL audio_unexpected got=%0d expected=no_change at tick %0d", audio, tick_cnt);
                end else begin
                    e = aud_q.pop_front();
                    check("audio_value", {28'h0, audio}, {28'h0, e.val});
                    if (e.ivl >= 0) check("audio_interval", tick_cnt - last_tick, e.ivl);
                end
            end
            last_aud  = audio;
            last_tick = tick_cnt;
        end
    endtask

    always @(negedge clk) mon_step();

    task automatic push_aud(input logic [3:0] v, input int ivl);
        aud_exp_t t;
        t.val = v;
        t.ivl = ivl;
        aud_q.push_back(t);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        cs = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0;
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!clken) @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int max_clk, input string tag);
        int n = 0;
        while ((aud_q.size() != 0 || rd_q.size() != 0) && n < max_clk) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (aud_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout pending_audio=%0d pending_reads=%0d expected=0", tag, aud_q.size(), rd_q.size());
            aud_q.delete();
            rd_q.delete();
        end
    endtask

    // Reference noise bit stream from the 0001 seed, converted into audio transitions at vol=8
    task automatic push_noise();
        logic [15:0] s;
        logic        o, o_prev;
        int          last_n;
        s      = 16'h0001;
        o_prev = 1'b1;
        last_n = 0;
        push_aud(4'd2, -1);
        for (int n = 1; n <= 64; n++) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
            o = s[0];
            if (o != o_prev) begin
                push_aud(o ? 4'd2 : 4'd0, 32 * (n - last_n));
                last_n = n;
                o_prev = o;
            end
        end
    endtask

    initial begin
        #(4000000);
        $display("FAIL watchdog expired tick=%0d", tick_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cs = 1'b0; we = 1'b0; addr = 4'h0; wdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_audio", {28'h0, audio}, 32'd0);
        check("reset_rdata", {24'h0, rdata}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_audio", {28'h0, audio}, 32'd0);
        rd(4'hA, 8'h00); rd(4'hB, 8'h00); rd(4'hC, 8'h00);
        rd(4'hD, 8'h00); rd(4'hE, 8'h00); rd(4'h9, 8'h00);
        wait_empty(20, "reset_reads");

        // Soprano F=7E: half-period 2 steps of 4 ticks, audio 15>>2=3
        push_aud(4'd3, -1); push_aud(4'd0, 8); push_aud(4'd3, 8);
        push_aud(4'd0, 8);  push_aud(4'd3, 8); push_aud(4'd0, 8);
        mon_en = 1'b1;
        wr(4'hE, 8'h0F);
        wr(4'hC, 8'h7E);
        wr(4'hC, 8'hFE);
        wait_empty(1000, "soprano");
        mon_en = 1'b0;
        wr(4'hC, 8'h00);
        settle(40);
        check("soprano_off_audio", {28'h0, audio}, 32'd0);

        // Bass F=0: 128 steps of 16 ticks per half-period, then disable mid-tone
        push_aud(4'd3, -1); push_aud(4'd0, 2048); push_aud(4'd3, 2048);
        mon_en = 1'b1;
        wr(4'hA, 8'h80);
        rd(4'hA, 8'h80);
        wait_empty(26000, "bass");
        push_aud(4'd0, -1);
        wr(4'hA, 8'h00);
        wait_empty(12, "bass_disable");
        mon_en = 1'b0;

        // Three voices at F=7F, started on the same tick: counts 0,1,1,2,1,2,2,3 per 4-tick block
        wr(4'hA, 8'h7F); wr(4'hB, 8'h7F); wr(4'hC, 8'h7F);
        push_aud(4'd3, -1); push_aud(4'd7, 8); push_aud(4'd3, 4);
        push_aud(4'd7, 4);  push_aud(4'd11, 8); push_aud(4'd0, 4);
        mon_en = 1'b1;
        wait_tick();
        wr(4'hA, 8'hFF); wr(4'hB, 8'hFF); wr(4'hC, 8'hFF);
        rd(4'hA, 8'hFF); rd(4'hB, 8'hFF);
        wait_empty(400, "chord");
        mon_en = 1'b0;
        wr(4'hA, 8'h00); wr(4'hB, 8'h00); wr(4'hC, 8'h00);
        settle(40);
        check("chord_off_audio", {28'h0, audio}, 32'd0);

        // Retune to F=70 on a wrap: one more 2-step half-period, then 16-step ones
        push_aud(4'd3, -1); push_aud(4'd0, 8); push_aud(4'd3, 8);
        push_aud(4'd0, 64); push_aud(4'd3, 64);
        mon_en = 1'b1;
        wr(4'hE, 8'h5F);
        wr(4'hC, 8'h7E);
        wait_tick();
        wr(4'hC, 8'hFE);
        for (int k = 1; k <= 15; k++) wait_tick();
        repeat (3) @(posedge clk);
        #1;
        wr(4'hC, 8'hF0);
        rd(4'hC, 8'hF0); rd(4'hE, 8'h5F);
        wait_empty(1000, "retune");
        mon_en = 1'b0;
        wr(4'hC, 8'h00);
        settle(40);
        check("retune_off_audio", {28'h0, audio}, 32'd0);

        // Noise at F=7F, vol 8: audio follows lfsr[0] as 2/0, one LFSR step per 32 ticks
        wr(4'hD, 8'h7F);
        wr(4'hE, 8'h08);
        push_noise();
        mon_en = 1'b1;
        wr(4'hD, 8'hFF);
        wait_empty(9000, "noise");
        mon_en = 1'b0;
        rd(4'hF, 8'h00); rd(4'h9, 8'h00); rd(4'hE, 8'h08); rd(4'hD, 8'hFF);
        wait_empty(20, "noise_reads");

        // Asynchronous reset while noise is audible
        n = 0;
        while (audio !== 4'd2 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("pre_reset_audio", {28'h0, audio}, 32'd2);
        reset = 1'b1;
        #1;
        check("midtone_reset_audio", {28'h0, audio}, 32'd0);
        check("midtone_reset_rdata", {24'h0, rdata}, 32'd0);
        settle(3);
        reset = 1'b0;
        rd(4'hD, 8'h00); rd(4'hE, 8'h00);
        wait_empty(20, "after_reset_reads");
        settle(40);
        check("after_reset_audio", {28'h0, audio}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
